handshake_rr_arbiter: RTL

- Shares one downstream ready/valid channel between N_REQ upstream ready/valid requesters carrying DATA_WIDTH-bit payloads.
- Default configuration is the three-lane handshake array feeding a single handshake port.
- Round-robin arbitration with bounded burst locking; the output is registered, with one-cycle latency and full throughput.
- Sits between the handshake_arr producers and the single-channel consumer in the foo datapath.

---
 rtl/handshake_rr_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging N_REQ ready/valid requesters onto one registered
// ready/valid output, with per-owner burst locking bounded by MAX_BURST beats.
module handshake_rr_arbiter #(
    parameter int N_REQ      = 3,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4,
    localparam int IDW = $clog2(N_REQ),
    localparam int CW  = $clog2(MAX_BURST + 1)
) (
    input  logic                        CLK,
    input  logic                        ASYNCRESET,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [IDW-1:0]              out_id,
    output logic                        dbg_locked,
    output logic [CW-1:0]               dbg_cnt
);

    // Handshake: a beat moves on a channel in any cycle where its valid and
    // ready are both high at the rising edge; valid may drop without a
    // transfer, and ready never depends on the payload.

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] owner, owner_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [CW-1:0]  cnt_beat;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] scan_base;
    logic           any_valid;
    logic           can_load;
    logic           accept;
    logic           owner_drop;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
        return (x == IDW'(N_REQ - 1)) ? '0 : x + IDW'(1);
    endfunction

    function automatic logic [IDW-1:0] first_valid(input logic [N_REQ-1:0] v,
                                                   input logic [IDW-1:0]   base);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] pick;
        logic           found;
        idx   = base;
        pick  = base;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    // A dropped owner releases the lock in the same cycle, so the scan
    // already starts past it and another requester can win immediately.
    always_comb begin
        any_valid  = |req_valid;
        can_load   = !out_valid || out_ready;
        owner_drop = (state == LOCKED) && !req_valid[owner];
        scan_base  = owner_drop ? wrap_inc(owner) : ptr;
        if ((state == LOCKED) && req_valid[owner]) begin
            sel = owner;
        end else begin
            sel = first_valid(req_valid, scan_base);
        end
        accept    = can_load && any_valid;
        req_ready = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        cnt_n    = cnt;
        ptr_n    = ptr;
        cnt_beat = ((state == LOCKED) && (sel == owner)) ? cnt + CW'(1) : CW'(1);
        if (owner_drop) begin
            state_n = IDLE;
            cnt_n   = '0;
            ptr_n   = wrap_inc(owner);
        end
        if (accept) begin
            owner_n = sel;
            if (cnt_beat == CW'(MAX_BURST)) begin
                state_n = IDLE;
                cnt_n   = '0;
                ptr_n   = wrap_inc(sel);
            end else begin
                state_n = LOCKED;
                cnt_n   = cnt_beat;
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state <= IDLE;
            owner <= '0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
        end
    end

    // Drain and reload in the same cycle simply overwrite the register.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
            out_id    <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign dbg_locked = (state == LOCKED);
    assign dbg_cnt    = cnt;

endmodule
